lane_scheduler: RTL and testbench
=================================

# lane_scheduler

Central sequencer for the obstacle lanes of the play field. It owns one shared frame-rate divider and one shared position-step datapath. On every divider tick it services all lanes in round-robin order, one lane per clock, and updates each lane's X position with edge wrap-around. The per-lane positions feed the sprite/draw logic directly, replacing free-running per-obstacle counters.

## Interface
- NUM_LANES, 4, number of obstacle lanes serviced (≥1)
- CNT_W, 22, divider counter width
- PERIOD_SLOW, 3000000, clocks per tick when stage2x=0 (≥NUM_LANES+2, <2^CNT_W)
- PERIOD_FAST, 1000000, clocks per tick when stage2x=1 (same bounds)
- X_MIN, 191, left wrap position
- X_MAX, 431, right wrap threshold
- frame_clk  in  1  sole clock; all logic on posedge
- Reset  in  1  synchronous, active-high reset
- run  in  1  1 = divider counts; 0 = divider holds
- stage2x  in  1  selects PERIOD_FAST when 1
- lane_center  in  NUM_LANES×10  per-lane start X, loaded on Reset
- lane_dir  in  NUM_LANES  per-lane direction: 0 = +1/right, 1 = −1/left
- lane_x  out  NUM_LANES×10  current per-lane X, registered
- step_pulse  out  NUM_LANES  one-cycle strobe: lane k moved this cycle
- busy  out  1  high while a sweep is in progress

## Operation
- Reset (sampled at clock edge): lane_x[k] ← lane_center[k]; divider ← 0; state ← IDLE; lane index ← 0; pending ← 0; step_pulse ← 0; busy ← 0.
- Divider:
  - Counts 0..P−1 while run=1, where P = stage2x ? PERIOD_FAST : PERIOD_SLOW.
  - tick = (run=1 and count==P−1). The count returns to 0 on tick.
  - A stage2x value differing from its registered copy of the previous cycle clears the count to 0 that cycle and suppresses tick.
- FSM states: IDLE, SWEEP.
  - IDLE → SWEEP on tick (or on pending=1, clearing pending); lane index ← 0.
  - SWEEP: each cycle, lane index i is stepped via the shared step unit, and step_pulse[i] is asserted. Then i ← i+1.
  - SWEEP → IDLE after i = NUM_LANES−1 is stepped.
- Step rule, 10-bit unsigned:
  - dir=0: next = (x > X_MAX) ? X_MIN : x+1.
  - dir=1: next = (x < X_MIN) ? X_MAX : x−1.
  - No wrap beyond these rules; 10-bit arithmetic never overflows within the legal ranges.
- lane_dir[i] is sampled in the cycle lane i is stepped.
- A tick during SWEEP sets pending (saturates at 1; further ticks are dropped). Pending starts a new sweep on the first IDLE cycle.
- run=0 mid-sweep: the sweep completes. Only the divider holds.
- Reset mid-sweep: the sweep is abandoned and all reset values are applied the next cycle.

## Timing
- Tick in cycle T → busy=1 in cycles T+1..T+NUM_LANES.
- Lane k's new value is visible on lane_x[k] from cycle T+1+k onward, and step_pulse[k]=1 only in cycle T+1+k.
- At most one step_pulse bit is high in any cycle.
- Pending sweep: starts one cycle after the previous sweep's last lane. busy stays low for exactly one IDLE cycle in between.
- Tick spacing: exactly P clocks while run=1 and stage2x is stable.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package lane_pkg holds: the FSM enum (IDLE, SWEEP), the direction encoding constants, and the default X_MIN/X_MAX.
- Sub-module lane_step_unit is the shared combinational next-X function (x, dir, X_MIN, X_MAX → next_x). It is instantiated once and muxed by lane index.

## Test plan
Benches override PERIOD_SLOW=8 and PERIOD_FAST=6 with NUM_LANES=4.
- Reset with lane_center={200,300,431,191}, run=1, dir all 0 → first tick at cycle 8 after reset release. lane_x becomes {201,301,432,192}, with step_pulse bits 0..3 in consecutive cycles.
- Wrap right: lane at 432, dir=0 → next step gives 191. Wrap left: lane at 190, dir=1 → next step gives 431. Lane at 191, dir=1 → 190.
- stage2x toggled 1 → count clears that cycle. Next tick comes 6 cycles later and then every 6; no tick in the toggle cycle.
- run=0 asserted during SWEEP at lane 1 → lanes 2–3 still step. No further ticks until run=1, and the count resumes from its held value.
- Reset asserted at lane 2 of a sweep → next cycle lane_x=lane_center, busy=0, step_pulse=0, and the first tick comes 8 cycles after Reset drops.
- Force a tick during SWEEP (hierarchical force of the divider) → pending sweep starts after one IDLE cycle. A second forced tick in the same sweep is dropped (exactly one extra sweep).

Source files
------------

// File: rtl/lane_pkg.sv
// rtl/lane_pkg.sv - shared types and constants for the obstacle lane scheduler
package lane_pkg;

   localparam int X_W = 10;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } lane_state_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   localparam logic [X_W-1:0] X_MIN_DEF = 10'd191;
   localparam logic [X_W-1:0] X_MAX_DEF = 10'd431;

endpackage

// File: rtl/lane_step_unit.sv
// rtl/lane_step_unit.sv - next-X function with edge wrap, shared by all lanes
module lane_step_unit
   import lane_pkg::*;
(
   input  logic [X_W-1:0] x_i,
   input  logic           dir_i,
   input  logic [X_W-1:0] x_min_i,
   input  logic [X_W-1:0] x_max_i,
   output logic [X_W-1:0] next_x_o
);

   // Wrap only once the position has stepped past the threshold.
   always_comb begin
      if (dir_i == DIR_LEFT) begin
         next_x_o = (x_i < x_min_i) ? x_max_i : x_i - X_W'(1);
      end else begin
         next_x_o = (x_i > x_max_i) ? x_min_i : x_i + X_W'(1);
      end
   end

endmodule

// File: rtl/lane_scheduler.sv
// rtl/lane_scheduler.sv - frame divider plus round-robin lane position sweep
module lane_scheduler
   import lane_pkg::*;
#(
   parameter int               NUM_LANES   = 4,
   parameter int               CNT_W       = 22,
   parameter int               PERIOD_SLOW = 3000000,
   parameter int               PERIOD_FAST = 1000000,
   parameter logic [X_W-1:0]   X_MIN       = X_MIN_DEF,
   parameter logic [X_W-1:0]   X_MAX       = X_MAX_DEF
) (
   input  logic                       frame_clk,
   input  logic                       Reset,
   input  logic                       run,
   input  logic                       stage2x,
   input  logic [NUM_LANES*X_W-1:0]   lane_center,
   input  logic [NUM_LANES-1:0]       lane_dir,
   output logic [NUM_LANES*X_W-1:0]   lane_x,
   output logic [NUM_LANES-1:0]       step_pulse,
   output logic                       busy
);

   localparam int IDX_W = $clog2(NUM_LANES + 1);
   localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(PERIOD_SLOW - 1);
   localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(PERIOD_FAST - 1);

   logic [CNT_W-1:0]         count_q, count_d, period_m1;
   logic                     stage_q, stage_chg, tick;
   lane_state_e              state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d, step_lane;
   logic                     pending_q, pending_d, do_step;
   logic [NUM_LANES*X_W-1:0] lane_x_q, lane_x_d;
   logic [NUM_LANES-1:0]     pulse_q, pulse_d;
   logic                     busy_q;
   logic [X_W-1:0]           cur_x, next_x;
   logic                     cur_dir;

   // A stage2x edge restarts the period so the new rate starts cleanly.
   assign period_m1 = stage2x ? FAST_M1 : SLOW_M1;
   assign stage_chg = (stage2x != stage_q);
   assign tick      = run && !stage_chg && (count_q == period_m1);

   always_comb begin
      count_d = count_q;
      if (stage_chg) begin
         count_d = '0;
      end else if (run) begin
         count_d = tick ? '0 : count_q + CNT_W'(1);
      end
   end

   // Lane 0 is stepped on the start edge, so idx_q names the next lane to step.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      do_step   = 1'b0;
      step_lane = idx_q;
      if (state_q == ST_IDLE) begin
         if (tick || pending_q) begin
            do_step   = 1'b1;
            step_lane = '0;
            idx_d     = IDX_W'(1);
            pending_d = 1'b0;
            state_d   = ST_SWEEP;
         end
      end else begin
         if (tick) begin
            pending_d = 1'b1;
         end
         if (idx_q == IDX_W'(NUM_LANES)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end else begin
            do_step = 1'b1;
            idx_d   = idx_q + IDX_W'(1);
         end
      end
   end

   always_comb begin
      cur_x   = '0;
      cur_dir = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (step_lane == IDX_W'(k)) begin
            cur_x   = lane_x_q[k*X_W +: X_W];
            cur_dir = lane_dir[k];
         end
      end
   end

   lane_step_unit u_step (
      .x_i      (cur_x),
      .dir_i    (cur_dir),
      .x_min_i  (X_MIN),
      .x_max_i  (X_MAX),
      .next_x_o (next_x)
   );

   always_comb begin
      lane_x_d = lane_x_q;
      pulse_d  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (do_step && (step_lane == IDX_W'(k))) begin
            lane_x_d[k*X_W +: X_W] = next_x;
            pulse_d[k]             = 1'b1;
         end
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         count_q   <= '0;
         stage_q   <= stage2x;
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
         lane_x_q  <= lane_center;
         pulse_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         stage_q   <= stage2x;
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         lane_x_q  <= lane_x_d;
         pulse_q   <= pulse_d;
         busy_q    <= (state_d == ST_SWEEP);
      end
   end

   assign lane_x     = lane_x_q;
   assign step_pulse = pulse_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// tb/tb_lane_scheduler.sv - scoreboard bench for lane_scheduler
module tb_lane_scheduler;

   localparam int NL = 4;
   localparam int XW = 10;

   logic             frame_clk = 1'b0;
   logic             Reset     = 1'b1;
   logic             run       = 1'b0;
   logic             stage2x   = 1'b0;
   logic [NL*XW-1:0] lane_center;
   logic [NL-1:0]    lane_dir;
   logic [NL*XW-1:0] lane_x;
   logic [NL-1:0]    step_pulse;
   logic             busy;

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;
   bit armed = 1'b0;
   int r, r2;

   typedef struct {
      int cyc;
      int lane;
      int x;
   } exp_t;

   exp_t sb[$];

   always #5 frame_clk = ~frame_clk;
   always @(posedge frame_clk) cyc <= cyc + 1;

   lane_scheduler #(
      .NUM_LANES   (NL),
      .CNT_W       (22),
      .PERIOD_SLOW (8),
      .PERIOD_FAST (6)
   ) dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .run         (run),
      .stage2x     (stage2x),
      .lane_center (lane_center),
      .lane_dir    (lane_dir),
      .lane_x      (lane_x),
      .step_pulse  (step_pulse),
      .busy        (busy)
   );

   function automatic int lx(int k);
      return int'(lane_x[k*XW +: XW]);
   endfunction

   task automatic chk(string nm, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic at(int c);
      while (cyc < c) begin
         @(posedge frame_clk);
         #1;
      end
   endtask

   task automatic exp_sweep(int t0, int n, int x0, int x1, int x2, int x3);
      int xs[4];
      xs = '{x0, x1, x2, x3};
      for (int k = 0; k < n; k++) sb.push_back('{t0 + k, k, xs[k]});
   endtask

   task automatic chk_reset_state(string tag);
      chk({tag, "_lane0"}, lx(0), 200);
      chk({tag, "_lane1"}, lx(1), 300);
      chk({tag, "_lane2"}, lx(2), 431);
      chk({tag, "_lane3"}, lx(3), 191);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_step_pulse"}, int'(step_pulse), 0);
   endtask

   always @(negedge frame_clk) begin
      if (armed && step_pulse != '0) begin
         exp_t e;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: step_pulse %b at cycle %0d, want none", step_pulse, cyc);
         end else begin
            e = sb.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_onehot", int'(step_pulse), 1 << e.lane);
            chk($sformatf("lane%0d_x", e.lane), lx(e.lane), e.x);
         end
      end
   end

   initial begin
      lane_center = {10'd191, 10'd431, 10'd300, 10'd200};
      lane_dir    = '0;
      Reset       = 1'b1;
      run         = 1'b1;
      stage2x     = 1'b0;
      repeat (3) @(posedge frame_clk);
      #1;
      Reset = 1'b0;
      r     = cyc;
      armed = 1'b1;

      exp_sweep(r + 8,  4, 201, 301, 432, 192);
      exp_sweep(r + 16, 4, 200, 302, 191, 191);
      exp_sweep(r + 24, 4, 199, 301, 190, 190);
      exp_sweep(r + 32, 4, 200, 302, 191, 431);
      exp_sweep(r + 44, 4, 201, 303, 192, 430);
      exp_sweep(r + 50, 4, 202, 304, 193, 429);
      exp_sweep(r + 56, 4, 203, 305, 194, 428);
      exp_sweep(r + 75, 3, 204, 306, 195, 0);

      chk_reset_state("reset");
      at(r + 7);  chk("busy_before_tick", int'(busy), 0);
      at(r + 8);  chk("busy_sweep_start", int'(busy), 1);
      at(r + 11); chk("busy_sweep_end", int'(busy), 1);
      at(r + 12); chk("busy_after_sweep", int'(busy), 0);
      lane_dir = 4'b1001;
      at(r + 20); lane_dir = 4'b1111;
      at(r + 28); lane_dir = 4'b1000;

      at(r + 37); stage2x = 1'b1;
      at(r + 38); chk("busy_no_toggle_tick", int'(busy), 0);
      at(r + 44); chk("busy_fast_sweep", int'(busy), 1);

      at(r + 57); run = 1'b0;
      at(r + 70); run = 1'b1;
      at(r + 74); chk("busy_held_divider", int'(busy), 0);
      at(r + 75); chk("busy_resumed_sweep", int'(busy), 1);

      at(r + 77);
      Reset    = 1'b1;
      stage2x  = 1'b0;
      lane_dir = '0;
      at(r + 78);
      Reset = 1'b0;
      r2    = cyc;
      chk_reset_state("midsweep_reset");

      exp_sweep(r2 + 8,  4, 201, 301, 432, 192);
      exp_sweep(r2 + 16, 4, 202, 302, 191, 193);
      exp_sweep(r2 + 21, 4, 203, 303, 192, 194);

      at(r2 + 16); run = 1'b0;
      at(r2 + 17); force dut.tick = 1'b1;
      at(r2 + 19); release dut.tick;
      chk("busy_last_lane", int'(busy), 1);
      at(r2 + 20); chk("busy_idle_gap", int'(busy), 0);
      at(r2 + 21); chk("busy_pending_sweep", int'(busy), 1);

      at(r2 + 40);
      chk("scoreboard_left", sb.size(), 0);
      chk("final_lane0", lx(0), 203);
      chk("final_lane1", lx(1), 303);
      chk("final_lane2", lx(2), 192);
      chk("final_lane3", lx(3), 194);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
